// File: rtl/parity_tx_pkg.sv
// Shared types and line levels for the parity serial transmitter.
// Frame = start + DATA_W data bits + parity + stop.
package parity_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic TX_IDLE_LVL  = 1'b1;
   localparam logic TX_STOP_LVL  = 1'b1;
   localparam logic TX_START_LVL = 1'b0;

   localparam int TX_DATA_W_DFLT = 8;

   function automatic int frame_len(input int data_w);
      return data_w + 3;
   endfunction

   localparam int TX_FRAME_LEN = frame_len(TX_DATA_W_DFLT);

endpackage

// File: rtl/parity_gen.sv
// Parity bit generator; odd parity when PARITY_TX_ODD_EN is defined, even otherwise.
// Latency: combinational.
// Backpressure: none, pure function of data.
module parity_gen #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   output logic              parity
);

`ifdef PARITY_TX_ODD_EN
   assign parity = ~^data;
`else
   assign parity = ^data;
`endif

endmodule

// File: rtl/parity_serial_tx.sv
// LSB-first serial transmitter: start, data, parity (PARITY_TX_ODD_EN selects odd), stop.
// Latency: tx drops to the start level 1 clk after accept; each bit advances on bit_en.
// Backpressure: din_ready only in IDLE; din/din_valid ignored for the whole frame.
module parity_serial_tx
   import parity_tx_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_en,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(DATA_W);

   tx_state_t         state, state_nxt;
   logic [DATA_W-1:0] shift_reg, shift_nxt;
   logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
   logic              parity_bit, parity_nxt;
   logic              parity_din;
   logic              tx_nxt;
   logic              done_nxt;
   logic              accept;

   parity_gen #(
      .DATA_W (DATA_W)
   ) u_parity_gen (
      .data   (din),
      .parity (parity_din)
   );

   assign din_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = din_valid && din_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
         tx         <= TX_IDLE_LVL;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         shift_reg  <= shift_nxt;
         bit_cnt    <= cnt_nxt;
         parity_bit <= parity_nxt;
         tx         <= tx_nxt;
         done       <= done_nxt;
      end
   end

   // tx is computed one step ahead so the line changes on the edge that moves the FSM.
   always_comb begin
      state_nxt  = state;
      shift_nxt  = shift_reg;
      cnt_nxt    = bit_cnt;
      parity_nxt = parity_bit;
      tx_nxt     = tx;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            tx_nxt = TX_IDLE_LVL;
            if (accept) begin
               state_nxt  = START;
               shift_nxt  = din;
               parity_nxt = parity_din;
               cnt_nxt    = '0;
               tx_nxt     = TX_START_LVL;
            end
         end
         START: begin
            if (bit_en) begin
               state_nxt = DATA;
               tx_nxt    = shift_reg[0];
            end
         end
         DATA: begin
            if (bit_en) begin
               shift_nxt = shift_reg >> 1;
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  state_nxt = PARITY;
                  tx_nxt    = parity_bit;
               end else begin
                  cnt_nxt = bit_cnt + CNT_W'(1);
                  tx_nxt  = shift_reg[1];
               end
            end
         end
         PARITY: begin
            if (bit_en) begin
               state_nxt = STOP;
               tx_nxt    = TX_STOP_LVL;
            end
         end
         STOP: begin
            if (bit_en) begin
               state_nxt = IDLE;
               tx_nxt    = TX_IDLE_LVL;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = TX_IDLE_LVL;
         end
      endcase
   end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Self-checking bench for parity_serial_tx; expected frames come from a bit-count parity model.
// Parity sense follows PARITY_TX_ODD_EN as compiled.
module tb_parity_serial_tx;

`ifdef PARITY_TX_ODD_EN
   localparam bit ODD = 1'b1;
`else
   localparam bit ODD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bit_en;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       tx;
   logic       busy;
   logic       done;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] cap_vec;
   int          cap_done;
   int          cap_busy;
   int          cap_ready_busy;
   logic        cap_tx_after   [0:3];
   logic        cap_busy_after [0:3];
   logic        cap_ready_done [0:3];
   logic        prev_done;

   parity_serial_tx #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_en    (bit_en),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .tx        (tx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Frame bit i is the i-th bit on the line: start, d[0..7], parity, stop.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      int   ones;
      logic par;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      par = ODD ? ((ones % 2) == 0) : ((ones % 2) == 1);
      return {1'b1, par, d, 1'b0};
   endfunction

   // Per-cycle observation at the negedge, before any input change.
   task automatic watch_cycle();
      if (busy && din_ready) cap_ready_busy++;
      if (prev_done && cap_done >= 1 && cap_done <= 4) begin
         cap_tx_after[cap_done-1]   = tx;
         cap_busy_after[cap_done-1] = busy;
         din_valid = 1'b0;
      end
      if (done) begin
         cap_done++;
         if (cap_done <= 4) cap_ready_done[cap_done-1] = din_ready;
      end
      prev_done = done;
   endtask

   // Pulses bit_en once every gap cycles, capturing tx just before each pulse.
   task automatic run_bits(input int nbits, input int gap, input int mid_at,
                           input logic [7:0] mid_din, input int drop_at);
      cap_vec = '0; cap_done = 0; cap_busy = 0; cap_ready_busy = 0; prev_done = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         for (int g = 0; g < gap; g++) begin
            watch_cycle();
            if (g == gap - 1) begin
               if (b == mid_at) din = mid_din;
               if (b == drop_at) din_valid = 1'b0;
               cap_vec[b] = tx;
               if (busy) cap_busy++;
               bit_en = 1'b1;
            end
            @(negedge clk);
            bit_en = 1'b0;
         end
      end
      repeat (3) begin
         watch_cycle();
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [10:0] exp;
      int bad;
      compared++; if (tx !== 1'b1)      begin mismatched++; $display("FAIL reset_tx: got %b want 1", tx); end
      compared++; if (busy !== 1'b0)    begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
      compared++; if (din_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", din_ready); end
      compared++; if (done !== 1'b0)    begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
      rst_n = 1'b1;
      @(negedge clk);
      din = 8'h3C; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      run_bits(2, 2, -1, 8'h00, -1);
      exp = model_frame(8'h3C);
      compared++; if (tx !== exp[2]) begin mismatched++; $display("FAIL midframe_tx_pre_reset: got %b want %b", tx, exp[2]); end
      #2 rst_n = 1'b0;
      #1;
      compared++; if (tx !== 1'b1)      begin mismatched++; $display("FAIL async_reset_tx: got %b want 1", tx); end
      compared++; if (busy !== 1'b0)    begin mismatched++; $display("FAIL async_reset_busy: got %b want 0", busy); end
      compared++; if (din_ready !== 1'b1) begin mismatched++; $display("FAIL async_reset_ready: got %b want 1", din_ready); end
      compared++; if (done !== 1'b0)    begin mismatched++; $display("FAIL async_reset_done: got %b want 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (12) begin
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
         bit_en = 1'b1;
         @(negedge clk);
      end
      bit_en = 1'b0;
      compared++; if (bad !== 0) begin mismatched++; $display("FAIL post_reset_idle: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_frame_a5();
      logic [31:0] exp;
      din = 8'hA5; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      run_bits(11, 4, -1, 8'h00, -1);
      exp = {21'b0, model_frame(8'hA5)};
      compared++; if (cap_vec !== exp) begin mismatched++; $display("FAIL a5_frame: got %h want %h", cap_vec, exp); end
      compared++; if (cap_done !== 1)  begin mismatched++; $display("FAIL a5_done_count: got %0d want 1", cap_done); end
      compared++; if (cap_busy !== 11) begin mismatched++; $display("FAIL a5_busy_periods: got %0d want 11", cap_busy); end
      compared++; if (cap_ready_done[0] !== 1'b1) begin mismatched++; $display("FAIL a5_ready_in_done: got %b want 1", cap_ready_done[0]); end
   endtask

   task automatic test_parity_cases();
      logic [7:0]  words [0:3];
      logic [10:0] exp;
      words[0] = 8'h07; words[1] = 8'h00; words[2] = 8'hFF; words[3] = 8'h01;
      for (int k = 0; k < 4; k++) begin
         din = words[k]; din_valid = 1'b1;
         @(negedge clk);
         din_valid = 1'b0;
         run_bits(11, 1, -1, 8'h00, -1);
         exp = model_frame(words[k]);
         compared++;
         if (cap_vec[9] !== exp[9]) begin
            mismatched++;
            $display("FAIL parity_%h: got %b want %b", words[k], cap_vec[9], exp[9]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  d;
      int          gap;
      logic [31:0] exp;
      for (int k = 0; k < 6; k++) begin
         d   = 8'($urandom_range(0, 255));
         gap = $urandom_range(1, 4);
         din = d; din_valid = 1'b1;
         @(negedge clk);
         din_valid = 1'b0;
         run_bits(11, gap, -1, 8'h00, -1);
         exp = {21'b0, model_frame(d)};
         compared++; if (cap_vec !== exp) begin mismatched++; $display("FAIL rand_frame_%h_gap%0d: got %h want %h", d, gap, cap_vec, exp); end
         compared++; if (cap_done !== 1)  begin mismatched++; $display("FAIL rand_done_%h: got %0d want 1", d, cap_done); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      din = 8'h11; din_valid = 1'b1;
      @(negedge clk);
      din = 8'h22;
      run_bits(22, 3, -1, 8'h00, -1);
      din_valid = 1'b0;
      exp = {10'b0, model_frame(8'h22), model_frame(8'h11)};
      compared++; if (cap_vec !== exp)  begin mismatched++; $display("FAIL b2b_frames: got %h want %h", cap_vec, exp); end
      compared++; if (cap_done !== 2)   begin mismatched++; $display("FAIL b2b_done_count: got %0d want 2", cap_done); end
      compared++; if (cap_ready_done[0] !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_in_done: got %b want 1", cap_ready_done[0]); end
      compared++; if (cap_tx_after[0] !== 1'b0)   begin mismatched++; $display("FAIL b2b_start_follows: got tx %b want 0", cap_tx_after[0]); end
      compared++; if (cap_busy_after[0] !== 1'b1) begin mismatched++; $display("FAIL b2b_busy_after_done: got %b want 1", cap_busy_after[0]); end
   endtask

   task automatic test_bit_en_idle();
      logic [31:0] exp;
      int bad;
      bad = 0;
      repeat (4) begin
         bit_en = 1'b1;
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      compared++; if (bad !== 0) begin mismatched++; $display("FAIL idle_bit_en: got %0d bad cycles want 0", bad); end
      din = 8'hC3; din_valid = 1'b1; bit_en = 1'b1;
      @(negedge clk);
      din_valid = 1'b0; bit_en = 1'b0;
      compared++; if (tx !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL accept_bit_en_start: got tx %b busy %b want 0 1", tx, busy); end
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (tx !== 1'b0) bad++;
      end
      compared++; if (bad !== 0) begin mismatched++; $display("FAIL start_bit_held: got %0d non-start cycles want 0", bad); end
      run_bits(11, 2, -1, 8'h00, -1);
      exp = {21'b0, model_frame(8'hC3)};
      compared++; if (cap_vec !== exp) begin mismatched++; $display("FAIL accept_bit_en_frame: got %h want %h", cap_vec, exp); end
      compared++; if (cap_done !== 1)  begin mismatched++; $display("FAIL accept_bit_en_done: got %0d want 1", cap_done); end
   endtask

   task automatic test_din_change();
      logic [31:0] exp;
      din = 8'h0F; din_valid = 1'b1;
      @(negedge clk);
      run_bits(11, 2, 4, 8'hFF, 10);
      exp = {21'b0, model_frame(8'h0F)};
      compared++; if (cap_vec !== exp)     begin mismatched++; $display("FAIL din_change_frame: got %h want %h", cap_vec, exp); end
      compared++; if (cap_ready_busy !== 0) begin mismatched++; $display("FAIL din_change_ready_busy: got %0d cycles want 0", cap_ready_busy); end
      compared++; if (cap_done !== 1)      begin mismatched++; $display("FAIL din_change_done: got %0d want 1", cap_done); end
      compared++; if (busy !== 1'b0)       begin mismatched++; $display("FAIL din_change_idle_after: got busy %b want 0", busy); end
   endtask

   initial begin
      rst_n = 1'b0; bit_en = 1'b0; din = 8'h00; din_valid = 1'b0; prev_done = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_frame_a5();
      test_parity_cases();
      test_random();
      test_back_to_back();
      test_bit_en_idle();
      test_din_change();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule
